// File: rtl/mult_rnd_sat_if.sv
// Sample bus for mult_rnd_sat: stage enable, operands and rounding mode in;
// rounded/saturated result, valid and saturation flag out.
interface mult_rnd_sat_if #(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 16,
  parameter int O_WIDTH = 16
);
  logic                      en_i;
  logic                      valid_i;
  logic signed [A_WIDTH-1:0] a_i;
  logic signed [B_WIDTH-1:0] b_i;
  logic [1:0]                mode_i;
  logic signed [O_WIDTH-1:0] mult_o;
  logic                      valid_o;
  logic                      sat_o;

  modport master (
    output en_i, valid_i, a_i, b_i, mode_i,
    input  mult_o, valid_o, sat_o
  );

  modport slave (
    input  en_i, valid_i, a_i, b_i, mode_i,
    output mult_o, valid_o, sat_o
  );
endinterface

// File: rtl/mult_rnd_sat.sv
// Pipelined signed fractional multiplier with per-sample rounding mode,
// output saturation and a whole-pipeline clock enable.
module mult_rnd_sat #(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 16,
  parameter int O_WIDTH = 16,
  parameter int FRAC    = 1,
  parameter int LATENCY = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mult_rnd_sat_if.slave bus
);
  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int D  = PW - FRAC - O_WIDTH;
  localparam logic signed [PW:0] ONE_D = (PW+1)'(1) << D;
  localparam logic signed [PW:0] HALF  = ONE_D >>> 1;
  localparam logic        [PW:0] MASK  = ONE_D - 1;

  if (O_WIDTH + FRAC > PW) begin : g_bad_width
    $error("mult_rnd_sat: O_WIDTH+FRAC must not exceed A_WIDTH+B_WIDTH");
  end
  if (LATENCY < 3) begin : g_bad_latency
    $error("mult_rnd_sat: LATENCY must be at least 3");
  end

  // One guard bit above the product keeps the rounding add from wrapping.
  function automatic logic signed [PW:0] round_fn(input logic signed [PW-1:0] p,
                                                  input logic [1:0]           mode);
    logic signed [PW:0] ext;
    logic signed [PW:0] win;
    logic signed [PW:0] up;
    logic               tie;
    ext = {p[PW-1], p};
    win = ext >>> D;
    up  = (ext + HALF) >>> D;
    tie = (D > 0) && ((ext & MASK) == HALF);
    case (mode)
      2'd1:    round_fn = up;
      2'd2:    round_fn = (tie && !win[0]) ? win : up;
      default: round_fn = win;
    endcase
  endfunction

  // Returns {sat, value}; every bit above the window MSB must match it.
  function automatic logic [O_WIDTH:0] sat_fn(input logic signed [PW:0] r);
    logic [PW-O_WIDTH+1:0] top;
    top = r[PW:O_WIDTH-1];
    if (top == '0 || top == '1) sat_fn = {1'b0, r[O_WIDTH-1:0]};
    else if (!r[PW])            sat_fn = {2'b10, {(O_WIDTH-1){1'b1}}};
    else                        sat_fn = {2'b11, {(O_WIDTH-1){1'b0}}};
  endfunction

  logic signed [A_WIDTH-1:0] a_p1_q, a_p1_d;
  logic signed [B_WIDTH-1:0] b_p1_q, b_p1_d;
  logic [1:0]                mode_p1_q, mode_p1_d;
  logic                      vld_p1_q, vld_p1_d;

  // Index is the stage number: 2 holds the fresh product, the rest are delay.
  logic signed [PW-1:0]      prod_pn_q [2:LATENCY-1];
  logic signed [PW-1:0]      prod_pn_d [2:LATENCY-1];
  logic [1:0]                mode_pn_q [2:LATENCY-1];
  logic [1:0]                mode_pn_d [2:LATENCY-1];
  logic                      vld_pn_q  [2:LATENCY-1];
  logic                      vld_pn_d  [2:LATENCY-1];

  logic signed [O_WIDTH-1:0] mult_q, mult_d;
  logic                      sat_q, sat_d;
  logic                      vld_o_q, vld_o_d;
  logic [O_WIDTH:0]          res;

  always_comb begin
    a_p1_d    = a_p1_q;
    b_p1_d    = b_p1_q;
    mode_p1_d = mode_p1_q;
    vld_p1_d  = vld_p1_q;
    for (int s = 2; s <= LATENCY-1; s++) begin
      prod_pn_d[s] = prod_pn_q[s];
      mode_pn_d[s] = mode_pn_q[s];
      vld_pn_d[s]  = vld_pn_q[s];
    end
    mult_d  = mult_q;
    sat_d   = sat_q;
    vld_o_d = vld_o_q;
    res     = sat_fn(round_fn(prod_pn_q[LATENCY-1], mode_pn_q[LATENCY-1]));

    if (bus.en_i) begin
      // stage 1: operand capture
      a_p1_d    = bus.a_i;
      b_p1_d    = bus.b_i;
      mode_p1_d = bus.mode_i;
      vld_p1_d  = bus.valid_i;
      // stage 2: full product
      prod_pn_d[2] = PW'(a_p1_q) * PW'(b_p1_q);
      mode_pn_d[2] = mode_p1_q;
      vld_pn_d[2]  = vld_p1_q;
      // stages 3..LATENCY-1: delay
      for (int s = 3; s <= LATENCY-1; s++) begin
        prod_pn_d[s] = prod_pn_q[s-1];
        mode_pn_d[s] = mode_pn_q[s-1];
        vld_pn_d[s]  = vld_pn_q[s-1];
      end
      // stage LATENCY: round, saturate, register
      mult_d  = res[O_WIDTH-1:0];
      sat_d   = res[O_WIDTH] & vld_pn_q[LATENCY-1];
      vld_o_d = vld_pn_q[LATENCY-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_p1_q    <= '0;
      b_p1_q    <= '0;
      mode_p1_q <= '0;
      vld_p1_q  <= 1'b0;
      for (int s = 2; s <= LATENCY-1; s++) begin
        prod_pn_q[s] <= '0;
        mode_pn_q[s] <= '0;
        vld_pn_q[s]  <= 1'b0;
      end
      mult_q  <= '0;
      sat_q   <= 1'b0;
      vld_o_q <= 1'b0;
    end else begin
      a_p1_q    <= a_p1_d;
      b_p1_q    <= b_p1_d;
      mode_p1_q <= mode_p1_d;
      vld_p1_q  <= vld_p1_d;
      for (int s = 2; s <= LATENCY-1; s++) begin
        prod_pn_q[s] <= prod_pn_d[s];
        mode_pn_q[s] <= mode_pn_d[s];
        vld_pn_q[s]  <= vld_pn_d[s];
      end
      mult_q  <= mult_d;
      sat_q   <= sat_d;
      vld_o_q <= vld_o_d;
    end
  end

  assign bus.mult_o  = mult_q;
  assign bus.valid_o = vld_o_q;
  assign bus.sat_o   = sat_q;
endmodule

// File: tb/tb_mult_rnd_sat.sv
// Directed bench for mult_rnd_sat at 16x16->16, FRAC=1, LATENCY=4.
module tb_mult_rnd_sat;
  localparam int AW  = 16;
  localparam int BW  = 16;
  localparam int OW  = 16;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_rnd_sat_if #(.A_WIDTH(AW), .B_WIDTH(BW), .O_WIDTH(OW)) bus ();

  mult_rnd_sat #(
    .A_WIDTH(AW), .B_WIDTH(BW), .O_WIDTH(OW), .FRAC(1), .LATENCY(LAT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  logic [15:0] mo;
  assign mo = bus.mult_o;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] s_a [8];
  logic [15:0] s_b [8];
  logic [1:0]  s_m [8];
  logic [15:0] e_y [8];
  logic        e_s [8];
  int          s_n;
  string       s_tag;

  task automatic put(input int i, input logic [15:0] a, input logic [15:0] b,
                     input logic [1:0] m, input logic [15:0] y, input logic s);
    s_a[i] = a; s_b[i] = b; s_m[i] = m; e_y[i] = y; e_s[i] = s;
  endtask

  // Back-to-back samples; result i is expected exactly LAT edges after capture.
  task automatic run_stream();
    int idx;
    for (int c = 0; c < s_n + LAT + 1; c++) begin
      if (c < s_n) begin
        bus.valid_i = 1'b1;
        bus.a_i     = s_a[c];
        bus.b_i     = s_b[c];
        bus.mode_i  = s_m[c];
      end else begin
        bus.valid_i = 1'b0;
      end
      step();
      idx = c - (LAT - 1);
      if (idx >= 0 && idx < s_n) begin
        check_eq($sformatf("%s_vld%0d", s_tag, idx), 32'(bus.valid_o), 32'd1);
        check_eq($sformatf("%s_y%0d", s_tag, idx), 32'(mo), 32'(e_y[idx]));
        check_eq($sformatf("%s_sat%0d", s_tag, idx), 32'(bus.sat_o), 32'(e_s[idx]));
      end else begin
        check_eq($sformatf("%s_idle%0d", s_tag, c), 32'(bus.valid_o), 32'd0);
        check_eq($sformatf("%s_idlesat%0d", s_tag, c), 32'(bus.sat_o), 32'd0);
      end
    end
    bus.valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          got;
    int          issued;
    logic [15:0] pmo;
    logic        pv;

    // Reset with a valid sample held on the inputs
    rst = 1'b1;
    bus.en_i = 1'b1; bus.valid_i = 1'b1;
    bus.a_i = 16'h4000; bus.b_i = 16'h4000; bus.mode_i = 2'd0;
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq($sformatf("rst_y%0d", c), 32'(mo), 32'h0);
      check_eq($sformatf("rst_vld%0d", c), 32'(bus.valid_o), 32'd0);
      check_eq($sformatf("rst_sat%0d", c), 32'(bus.sat_o), 32'd0);
    end
    rst = 1'b0;
    bus.valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq($sformatf("post_rst_y%0d", c), 32'(mo), 32'h0);
      check_eq($sformatf("post_rst_vld%0d", c), 32'(bus.valid_o), 32'd0);
      check_eq($sformatf("post_rst_sat%0d", c), 32'(bus.sat_o), 32'd0);
    end

    // Latency and basic product: 0.5 * 0.5 = 0.25
    s_tag = "basic"; s_n = 1;
    put(0, 16'h4000, 16'h4000, 2'd0, 16'h2000, 1'b0);
    run_stream();

    // Rounding ties with mode changing every sample
    s_tag = "ties"; s_n = 6;
    put(0, 16'h0001, 16'hC000, 2'd0, 16'hFFFF, 1'b0);
    put(1, 16'h0001, 16'hC000, 2'd1, 16'h0000, 1'b0);
    put(2, 16'h0001, 16'hC000, 2'd2, 16'h0000, 1'b0);
    put(3, 16'h0003, 16'hC000, 2'd0, 16'hFFFE, 1'b0);
    put(4, 16'h0003, 16'hC000, 2'd1, 16'hFFFF, 1'b0);
    put(5, 16'h0003, 16'hC000, 2'd2, 16'hFFFE, 1'b0);
    run_stream();

    // Saturation of -1 * -1, then the largest non-saturating product
    s_tag = "sat"; s_n = 3;
    put(0, 16'h8000, 16'h8000, 2'd0, 16'h7FFF, 1'b1);
    put(1, 16'h7FFF, 16'h7FFF, 2'd0, 16'h7FFE, 1'b0);
    put(2, 16'h7FFF, 16'h7FFF, 2'd3, 16'h7FFE, 1'b0);
    run_stream();

    // Stall: a=1..6 * 0x7FFF rounded half up gives 1..6; en low for 2 cycles
    got = 0;
    issued = 0;
    for (int c = 0; c < 20; c++) begin
      bus.en_i = !(c == 3 || c == 4);
      if (!bus.en_i) begin
        bus.valid_i = 1'b1; bus.a_i = 16'h0055; bus.b_i = 16'h7FFF; bus.mode_i = 2'd0;
      end else if (issued < 6) begin
        bus.valid_i = 1'b1; bus.a_i = 16'(issued + 1); bus.b_i = 16'h7FFF; bus.mode_i = 2'd1;
        issued++;
      end else begin
        bus.valid_i = 1'b0;
      end
      pmo = mo;
      pv  = bus.valid_o;
      step();
      if (!bus.en_i) begin
        check_eq($sformatf("stall_hold_y%0d", c), 32'(mo), 32'(pmo));
        check_eq($sformatf("stall_hold_vld%0d", c), 32'(bus.valid_o), 32'(pv));
      end else if (bus.valid_o) begin
        if (got < 6) check_eq($sformatf("stall_y%0d", got), 32'(mo), 32'(got + 1));
        got++;
      end
    end
    bus.en_i = 1'b1;
    bus.valid_i = 1'b0;
    check_eq("stall_count", 32'(got), 32'd6);

    // Reset with three samples in flight
    bus.valid_i = 1'b1; bus.a_i = 16'h4000; bus.b_i = 16'h4000; bus.mode_i = 2'd0;
    for (int c = 0; c < 3; c++) step();
    bus.valid_i = 1'b0;
    rst = 1'b1;
    step();
    check_eq("midrst_vld", 32'(bus.valid_o), 32'd0);
    rst = 1'b0;
    s_tag = "after_rst"; s_n = 1;
    put(0, 16'h2000, 16'h4000, 2'd0, 16'h1000, 1'b0);
    run_stream();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
